// File: rtl/unidad_acceso_memoria_if.sv
// Memory-side req/ack bus of the load/store unit.
//   master (load/store unit): drives Mem_Req, Mem_We, Mem_Dir, Mem_Byte_En,
//                             Mem_Dato_Esc; receives Mem_Ack, Mem_Dato_Lec
//   slave  (data memory):     the mirror image
interface unidad_acceso_memoria_if;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Dir;
  logic [3:0]  Mem_Byte_En;
  logic [31:0] Mem_Dato_Esc;
  logic        Mem_Ack;
  logic [31:0] Mem_Dato_Lec;

  modport master (
    output Mem_Req, Mem_We, Mem_Dir, Mem_Byte_En, Mem_Dato_Esc,
    input  Mem_Ack, Mem_Dato_Lec
  );

  modport slave (
    input  Mem_Req, Mem_We, Mem_Dir, Mem_Byte_En, Mem_Dato_Esc,
    output Mem_Ack, Mem_Dato_Lec
  );
endinterface

// File: rtl/unidad_acceso_memoria.sv
// Multi-cycle load/store unit between the datapath and the synchronous data
// memory. One request per transaction; drives a req/ack memory port with
// word-aligned address, byte enables and lane-replicated store data, and
// returns sign/zero-extended load data.
//   clk, rst            clock, synchronous active-high reset
//   Inicio              request strobe (sampled only when idle)
//   Escritura, Funct3   store/load select and access size/sign
//   Direccion           byte address
//   Dato_Escritura      store data
//   Dato_Leido          registered, extended load result
//   Listo               one-cycle completion pulse
//   Ocupado             high while waiting for the memory (pipeline stall)
//   Error_Alineamiento  misaligned / illegal Funct3, valid with Listo
//   Error_Bus           memory timeout, valid with Listo
//   mem                 memory bus (master side)
module unidad_acceso_memoria #(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Inicio,
  input  logic        Escritura,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Direccion,
  input  logic [31:0] Dato_Escritura,
  output logic [31:0] Dato_Leido,
  output logic        Listo,
  output logic        Ocupado,
  output logic        Error_Alineamiento,
  output logic        Error_Bus,
  unidad_acceso_memoria_if.master mem
);

  typedef enum logic [1:0] {
    REPOSO = 2'b00,
    ESPERA = 2'b01,
    FIN    = 2'b10
  } estado_t;

  localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS - 1);

  estado_t     estado, estado_sig;
  logic        funct_ok, desalineado, pedido_valido;
  logic [3:0]  be_sig;
  logic [31:0] dato_sig;
  logic        lanzar, rechazar, ack_ok, expira;
  logic        escritura_q;
  logic [2:0]  funct3_q;
  logic [1:0]  k_q;
  logic [7:0]  cuenta;
  logic [31:0] palabra, extendido;

  // Request decode and store lane formatting from the live inputs.
  always_comb begin
    funct_ok = 1'b0;
    if (Escritura)
      funct_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
    else
      funct_ok = (Funct3[1:0] != 2'b11) && (Funct3 != 3'b110);
    desalineado = ((Funct3[1:0] == 2'b01) && Direccion[0]) ||
                  ((Funct3[1:0] == 2'b10) && (Direccion[1:0] != 2'b00));
    pedido_valido = funct_ok && !desalineado;

    be_sig   = 4'b1111;
    dato_sig = '0;
    if (Escritura) begin
      case (Funct3[1:0])
        2'b00: begin
          be_sig   = 4'b0001 << Direccion[1:0];
          dato_sig = {4{Dato_Escritura[7:0]}};
        end
        2'b01: begin
          be_sig   = 4'b0011 << Direccion[1:0];
          dato_sig = {2{Dato_Escritura[15:0]}};
        end
        default: dato_sig = Dato_Escritura;
      endcase
    end
  end

  // Load data alignment and extension from the latched request.
  always_comb begin
    palabra   = mem.Mem_Dato_Lec >> {k_q, 3'b000};
    extendido = palabra;
    case (funct3_q)
      3'b000:  extendido = {{24{palabra[7]}}, palabra[7:0]};
      3'b100:  extendido = {24'd0, palabra[7:0]};
      3'b001:  extendido = {{16{palabra[15]}}, palabra[15:0]};
      3'b101:  extendido = {16'd0, palabra[15:0]};
      default: extendido = palabra;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    lanzar     = 1'b0;
    rechazar   = 1'b0;
    ack_ok     = 1'b0;
    expira     = 1'b0;
    case (estado)
      REPOSO: begin
        if (Inicio) begin
          if (pedido_valido) begin
            lanzar     = 1'b1;
            estado_sig = ESPERA;
          end else begin
            rechazar   = 1'b1;
            estado_sig = FIN;
          end
        end
      end
      ESPERA: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (mem.Mem_Ack) begin
          ack_ok     = 1'b1;
          estado_sig = FIN;
        end else if (cuenta == LIMITE) begin
          expira     = 1'b1;
          estado_sig = FIN;
        end
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  assign Listo   = (estado == FIN);
  assign Ocupado = (estado == ESPERA);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem.Mem_Req        <= 1'b0;
      mem.Mem_We         <= 1'b0;
      mem.Mem_Dir        <= '0;
      mem.Mem_Byte_En    <= '0;
      mem.Mem_Dato_Esc   <= '0;
      Dato_Leido         <= '0;
      Error_Alineamiento <= 1'b0;
      Error_Bus          <= 1'b0;
      escritura_q        <= 1'b0;
      funct3_q           <= '0;
      k_q                <= '0;
      cuenta             <= '0;
    end else begin
      // Flags are only set on entry to FIN, so they last exactly one cycle.
      Error_Alineamiento <= rechazar;
      Error_Bus          <= expira;
      if (lanzar) begin
        mem.Mem_Req      <= 1'b1;
        mem.Mem_We       <= Escritura;
        mem.Mem_Dir      <= {Direccion[31:2], 2'b00};
        mem.Mem_Byte_En  <= be_sig;
        mem.Mem_Dato_Esc <= dato_sig;
        escritura_q      <= Escritura;
        funct3_q         <= Funct3;
        k_q              <= Direccion[1:0];
        cuenta           <= '0;
      end
      if (estado == ESPERA) cuenta <= cuenta + 8'd1;
      if (ack_ok || expira) mem.Mem_Req <= 1'b0;
      if (ack_ok && !escritura_q) Dato_Leido <= extendido;
      if (expira && !escritura_q) Dato_Leido <= '0;
    end
  end

endmodule
